// File: rtl/ped_request_ctrl_if.sv
// Walk-request handshake between the pedestrian conditioner and the sequencer.
// The requester (master) holds req as a level and receives a one-cycle ack pulse.
interface ped_request_ctrl_if;
  logic req;
  logic ack;

  modport master (output req, input ack);
  modport slave  (input req, output ack);
endinterface

// File: rtl/ped_request_ctrl.sv
// Pedestrian push-button conditioner: sync, debounce, rising-edge detect, walk request FSM with hold-off.
// Optional blinking wait lamp is built only when PED_BLINK_EN is defined.
module ped_request_ctrl #(
  parameter logic [31:0] DB_CYCLES      = 32'd1000000,
  parameter logic [31:0] HOLDOFF_CYCLES = 32'd500000000,
  parameter logic [31:0] BLINK_CYCLES   = 32'd50000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_i,
  ped_request_ctrl_if.master  walk,
  output logic                pending_led_o,
  output logic [7:0]          press_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  logic        syncA_q, syncB_q;
  logic [31:0] dbCnt_q;
  logic        dbState_q, dbStateDly_q;
  logic        press;

  state_t      state_q, state_d;
  logic [31:0] holdCnt_q, holdCnt_d;
  logic [7:0]  pressCnt_q, pressCnt_d;
  logic        reqInt;

  // A level is accepted only after DB_CYCLES consecutive cycles away from the current debounced state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncA_q      <= 1'b0;
      syncB_q      <= 1'b0;
      dbCnt_q      <= '0;
      dbState_q    <= 1'b0;
      dbStateDly_q <= 1'b0;
    end else begin
      syncA_q      <= btn_i;
      syncB_q      <= syncA_q;
      dbStateDly_q <= dbState_q;
      if (syncB_q == dbState_q) begin
        dbCnt_q <= '0;
      end else if (dbCnt_q == DB_CYCLES - 32'd1) begin
        dbState_q <= syncB_q;
        dbCnt_q   <= '0;
      end else begin
        dbCnt_q <= dbCnt_q + 32'd1;
      end
    end
  end

  assign press = dbState_q & ~dbStateDly_q;

  always_comb begin
    state_d    = state_q;
    holdCnt_d  = holdCnt_q;
    pressCnt_d = pressCnt_q;
    case (state_q)
      IDLE: begin
        if (press) begin
          state_d    = PENDING;
          pressCnt_d = pressCnt_q + 8'd1;
        end
      end
      PENDING: begin
        if (walk.ack) begin
          state_d   = HOLDOFF;
          holdCnt_d = '0;
        end
      end
      // Presses landing here are dropped, not queued, so vehicle phases cannot be starved.
      HOLDOFF: begin
        if (holdCnt_q == HOLDOFF_CYCLES - 32'd1) begin
          state_d   = IDLE;
          holdCnt_d = '0;
        end else begin
          holdCnt_d = holdCnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      holdCnt_q  <= '0;
      pressCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      holdCnt_q  <= holdCnt_d;
      pressCnt_q <= pressCnt_d;
    end
  end

  assign reqInt      = (state_q == PENDING);
  assign walk.req    = reqInt;
  assign press_cnt_o = pressCnt_q;

`ifdef PED_BLINK_EN
  logic [31:0] blinkCnt_q;
  logic        blinkDark_q;

  // Phase is stored as "dark" so its cleared value lights the lamp on the first cycle of req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blinkCnt_q  <= '0;
      blinkDark_q <= 1'b0;
    end else if (state_q != PENDING || state_d != PENDING) begin
      blinkCnt_q  <= '0;
      blinkDark_q <= 1'b0;
    end else if (blinkCnt_q == BLINK_CYCLES - 32'd1) begin
      blinkCnt_q  <= '0;
      blinkDark_q <= ~blinkDark_q;
    end else begin
      blinkCnt_q <= blinkCnt_q + 32'd1;
    end
  end

  assign pending_led_o = reqInt & ~blinkDark_q;
`else
  logic unusedBlinkCfg;
  assign unusedBlinkCfg = ^BLINK_CYCLES;
  assign pending_led_o  = reqInt;
`endif

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Directed self-checking bench for ped_request_ctrl with DB_CYCLES=4, HOLDOFF_CYCLES=10, BLINK_CYCLES=3.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_ped_request_ctrl;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       led;
  logic [7:0] cnt;
  int         total;
  int         bad;

  ped_request_ctrl_if pif ();

  ped_request_ctrl #(
    .DB_CYCLES      (32'd4),
    .HOLDOFF_CYCLES (32'd10),
    .BLINK_CYCLES   (32'd3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_i         (btn),
    .walk          (pif.master),
    .pending_led_o (led),
    .press_cnt_o   (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic btnVal, input logic ackVal, input int cycles);
    btn     = btnVal;
    pif.ack = ackVal;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic doRequest();
    int w;
    w = 0;
    applyStimulus(1'b1, 1'b0, 1);
    while (!pif.req && w < 20) begin
      applyStimulus(1'b1, 1'b0, 1);
      w++;
    end
    checkOutput("wrapReqRise", {31'd0, pif.req}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 20);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    btn     = 1'b1;
    pif.ack = 1'b0;

    // Reset state, then a clean held press: req appears after edge 7.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstReq", {31'd0, pif.req}, 32'd0);
    checkOutput("rstLed", {31'd0, led}, 32'd0);
    checkOutput("rstCnt", {24'd0, cnt}, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 6);
    checkOutput("latEdge6", {31'd0, pif.req}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("latEdge7", {31'd0, pif.req}, 32'd1);
    checkOutput("firstCnt", {24'd0, cnt}, 32'd1);
    checkOutput("firstLed", {31'd0, led}, 32'd1);

    // Button held through ack: one request only, none after hold-off.
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("ackDropsReq", {31'd0, pif.req}, 32'd0);
    applyStimulus(1'b1, 1'b0, 40);
    checkOutput("heldNoReReq", {31'd0, pif.req}, 32'd0);
    checkOutput("heldCnt", {24'd0, cnt}, 32'd1);
    applyStimulus(1'b0, 1'b0, 10);

    // Ack in IDLE is ignored.
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("ackIdle", {31'd0, pif.req}, 32'd0);
    applyStimulus(1'b0, 1'b0, 2);

    // Bounce shorter than the debounce window, then a stable rise.
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("bounceNoReq", {31'd0, pif.req}, 32'd0);
    applyStimulus(1'b1, 1'b0, 6);
    checkOutput("bounceEdge6", {31'd0, pif.req}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("bounceEdge7", {31'd0, pif.req}, 32'd1);
    checkOutput("bounceCnt", {24'd0, cnt}, 32'd2);

    // Release while pending keeps req; a press during hold-off is dropped.
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("pendingHold", {31'd0, pif.req}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("ack2DropsReq", {31'd0, pif.req}, 32'd0);
    applyStimulus(1'b1, 1'b0, 25);
    checkOutput("holdoffPressReq", {31'd0, pif.req}, 32'd0);
    checkOutput("holdoffPressCnt", {24'd0, cnt}, 32'd2);
    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b1, 1'b0, 6);
    checkOutput("press3Edge6", {31'd0, pif.req}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("press3Edge7", {31'd0, pif.req}, 32'd1);
    checkOutput("press3Cnt", {24'd0, cnt}, 32'd3);

    // Lamp while pending: steady by default, 3 on / 3 off with blinking built in.
    for (int i = 0; i < 7; i++) begin
      logic expLed;
`ifdef PED_BLINK_EN
      expLed = ((i % 6) < 3);
`else
      expLed = 1'b1;
`endif
      checkOutput($sformatf("led%0d", i), {31'd0, led}, {31'd0, expLed});
      applyStimulus(1'b1, 1'b0, 1);
    end
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("ledAfterAck", {31'd0, led}, 32'd0);

    // Asynchronous reset while req is high.
    applyStimulus(1'b0, 1'b0, 20);
    applyStimulus(1'b1, 1'b0, 7);
    checkOutput("press4Req", {31'd0, pif.req}, 32'd1);
    checkOutput("press4Cnt", {24'd0, cnt}, 32'd4);
    btn = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("asyncRstReq", {31'd0, pif.req}, 32'd0);
    checkOutput("asyncRstLed", {31'd0, led}, 32'd0);
    checkOutput("asyncRstCnt", {24'd0, cnt}, 32'd0);
    applyStimulus(1'b0, 1'b0, 2);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("postRstReq", {31'd0, pif.req}, 32'd0);

    // Counter wraps 255 -> 0.
    for (int k = 0; k < 256; k++) begin
      doRequest();
      if (k == 254) checkOutput("cnt255", {24'd0, cnt}, 32'd255);
    end
    checkOutput("cntWrap", {24'd0, cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ped_request_ctrl.md
Name: ped_request_ctrl

Overview:
- Upstream stage of the traffic light sequencer. Conditions a raw pedestrian push-button: synchronise, debounce, then detect the rising edge.
- Holds a walk request to the sequencer with a level req / pulse ack handshake.
- After each grant, enforces a hold-off window so repeated presses cannot starve vehicle phases.
- Drives a "request pending" lamp and keeps a count of accepted requests.

Parameters:
- DB_CYCLES, 32'd1000000, clock cycles a synchronised button level must stay stable before it is accepted (10 ms at 100 MHz); minimum 2.
- HOLDOFF_CYCLES, 32'd500000000, clock cycles after ack during which presses are ignored (5 s at 100 MHz); minimum 1.
- BLINK_CYCLES, 32'd50000000, half-period of the pending-lamp blink; used only with PED_BLINK_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn  input  1  raw push-button, asynchronous to clk, may bounce.
- ack  input  1  one-cycle pulse from the sequencer when the walk phase starts.
- req  output  1  walk request to the sequencer; level, held until ack.
- pending_led  output  1  pedestrian "wait" lamp.
- press_cnt  output  8  number of accepted requests; wraps 255 -> 0.

Behaviour:
- Reset and clocking:
  - clk is the single clock. rst is asynchronous and active-high.
  - On rst, every register clears: sync flops, debounce counter, db_state, db_state_d, FSM = IDLE, hold_cnt, blink counter/phase, press_cnt.
  - Reset outputs: req=0, pending_led=0, press_cnt=0.
  - Reset asserted mid-operation drops req immediately (asynchronously) and discards any pending request.
- Synchroniser: btn -> s1 -> s2, two flops.
- Debounce:
  - If s2 == db_state: counter <= 0.
  - Otherwise counter increments. When it equals DB_CYCLES-1 and s2 still differs: db_state <= s2, counter <= 0.
  - Any bounce back to the db_state level restarts the count from 0.
  - Counter is 32-bit and never wraps, because it is bounded by DB_CYCLES.
- Edge detect:
  - db_state_d <= db_state.
  - press = db_state & ~db_state_d, a single-cycle pulse.
  - The release edge is ignored.
- FSM, 2-bit state register:
  - IDLE: press -> PENDING; press_cnt <= press_cnt+1.
  - PENDING: ack -> HOLDOFF, hold_cnt <= 0. press is ignored here (no count increment).
  - HOLDOFF: hold_cnt increments; at HOLDOFF_CYCLES-1 -> IDLE. press is ignored and dropped, not queued.
  - Unused encoding -> IDLE.
- Outputs:
  - req = (state == PENDING), decoded from the state register with no extra cycle.
  - pending_led = req (steady) unless PED_BLINK_EN is defined.
- Latency: a clean btn rise sampled at edge 1 gives req=1 after edge DB_CYCLES+3.
- Simultaneous events:
  - press and ack in the same cycle in IDLE: press is taken; ack is ignored because no request is outstanding.
  - ack in IDLE or HOLDOFF: ignored.
  - ack with no preceding req: no state change.
- Button held continuously: yields exactly one request. A new request needs a release recognised by the debouncer, then a new press.

Optional Feature:
- Macro: PED_BLINK_EN.
- Defined:
  - A blink counter runs only in PENDING and toggles the phase every BLINK_CYCLES cycles.
  - pending_led = req & phase. Phase is 1 on PENDING entry, so the lamp lights in the first cycle of req.
  - Counter and phase clear whenever the FSM leaves PENDING.
- Undefined: no blink logic is synthesised; pending_led = req.

Test Plan (DB_CYCLES=4, HOLDOFF_CYCLES=10, BLINK_CYCLES=3):
1. Reset: rst=1 with btn=1 -> req=0, pending_led=0, press_cnt=0. Release rst, hold btn=1 -> req=1 after edge 7, press_cnt=1.
2. Bounce: btn toggles 1,0,1,0 every 2 cycles, then stays 1 -> no req during the toggling; req rises 7 edges after the final rise; press_cnt increments once only.
3. Handshake: req=1, pulse ack for 1 cycle -> req=0 on the next edge, state HOLDOFF. A clean press during the 10 hold-off cycles -> req stays 0, press_cnt unchanged. A press after hold-off -> req=1, press_cnt=2.
4. Held button: btn held 1 for 100 cycles through ack -> exactly one request, no re-request after hold-off expires. Release, then press again -> second request.
5. Reset mid-operation: assert rst asynchronously while req=1 -> req falls before the next clk edge; state IDLE, press_cnt=0.
6. Blink (PED_BLINK_EN): in PENDING, pending_led = 1,1,1,0,0,0,1... repeating every 6 cycles. After ack, pending_led=0. Wrap check: 256 accepted requests -> press_cnt returns to 0.
